// File: rtl/mux_pkg.sv
// Shared definitions for the arbitrated N-to-1 muxes: arbitration modes and
// the packed-channel slicing helper used on in_data.
package mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Channel i of a packed bus occupies [i*width +: width]; this returns the low bit.
    function automatic int sliceLo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/mux_arb.sv
// Combinational arbiter: picks one requesting channel, either lowest index first
// or searching upward from the round-robin pointer with wrap at NCH.
module mux_arb
    import mux_pkg::*;
#(
    parameter  int NCH  = 4,
    parameter  int MODE = MODE_RR,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  i_valid,
    input  logic [SELW-1:0] i_ptr,
    output logic [NCH-1:0]  o_grant,
    output logic [SELW-1:0] o_gidx
);

    logic w_found;

    // Visit channels in priority order; the search start only moves in round-robin mode.
    always_comb begin
        o_grant = '0;
        o_gidx  = '0;
        w_found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            int idx;
            idx = (MODE == MODE_RR) ? int'(i_ptr) + k : k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!w_found && i_valid[idx]) begin
                w_found      = 1'b1;
                o_grant[idx] = 1'b1;
                o_gidx       = idx[SELW-1:0];
            end
        end
    end

endmodule

// File: rtl/muxnto1_rr.sv
// Registered N-to-1 mux with valid/ready handshake; the source channel is chosen
// by the internal arbiter and reported alongside each output word.
module muxnto1_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    parameter  int MODE  = MODE_RR,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    logic                r_valid;
    logic [WIDTH-1:0]    r_data;
    logic [SELW-1:0]     r_sel;
    logic [SELW-1:0]     r_ptr;

    logic                w_ld;
    logic                w_xfer;
    logic [NCH-1:0]      w_grant;
    logic [SELW-1:0]     w_gidx;
    logic [WIDTH-1:0]    w_selData;

    mux_arb #(
        .NCH  (NCH),
        .MODE (MODE)
    ) u_arb (
        .i_valid (in_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_gidx  (w_gidx)
    );

    // The register can take a word when empty or when its current word is leaving.
    assign w_ld      = !r_valid || out_ready;
    assign w_xfer    = w_ld && (|w_grant);
    assign in_ready  = (rst_n && w_ld) ? w_grant : '0;
    assign w_selData = in_data[sliceLo(int'(w_gidx), WIDTH) +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else if (w_ld) begin
            if (w_xfer) begin
                r_valid <= 1'b1;
                r_data  <= w_selData;
                r_sel   <= w_gidx;
                // Pointer wraps at NCH, not at the power of two above it.
                if (MODE == MODE_RR) begin
                    if (int'(w_gidx) == NCH - 1) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= w_gidx + SELW'(1);
                    end
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_sel   = r_sel;

endmodule

// File: tb/tb_muxnto1_rr.sv
// Bench for muxnto1_rr: three instances (4-ch round-robin, 4-ch fixed priority,
// 3-ch round-robin) driven by directed tables, corner sequences and random traffic.
module tb_muxnto1_rr;

    logic        clk;
    logic        rst_n;

    logic [3:0]  rrValid;
    logic [31:0] rrData;
    logic [3:0]  rrInReady;
    logic        rrOutValid;
    logic [7:0]  rrOutData;
    logic [1:0]  rrOutSel;
    logic        rrOutReady;

    logic [3:0]  fxValid;
    logic [31:0] fxData;
    logic [3:0]  fxInReady;
    logic        fxOutValid;
    logic [7:0]  fxOutData;
    logic [1:0]  fxOutSel;
    logic        fxOutReady;

    logic [2:0]  t3Valid;
    logic [23:0] t3Data;
    logic [2:0]  t3InReady;
    logic        t3OutValid;
    logic [7:0]  t3OutData;
    logic [1:0]  t3OutSel;
    logic        t3OutReady;

    int total;
    int bad;

    muxnto1_rr #(.WIDTH(8), .NCH(4), .MODE(1)) dutRr (
        .clk(clk), .rst_n(rst_n),
        .in_valid(rrValid), .in_data(rrData), .in_ready(rrInReady),
        .out_valid(rrOutValid), .out_data(rrOutData), .out_sel(rrOutSel),
        .out_ready(rrOutReady)
    );

    muxnto1_rr #(.WIDTH(8), .NCH(4), .MODE(0)) dutFx (
        .clk(clk), .rst_n(rst_n),
        .in_valid(fxValid), .in_data(fxData), .in_ready(fxInReady),
        .out_valid(fxOutValid), .out_data(fxOutData), .out_sel(fxOutSel),
        .out_ready(fxOutReady)
    );

    muxnto1_rr #(.WIDTH(8), .NCH(3), .MODE(1)) dutT3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(t3Valid), .in_data(t3Data), .in_ready(t3InReady),
        .out_valid(t3OutValid), .out_data(t3OutData), .out_sel(t3OutSel),
        .out_ready(t3OutReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rrV;
        logic [3:0] fxV;
        logic [3:0] rrIr;
        logic [1:0] rrSel;
        logic [7:0] rrDat;
        logic [3:0] fxIr;
        logic [1:0] fxSel;
        logic [7:0] fxDat;
    } vec_t;

    vec_t tbl[6];

    // Reference model state, one slot per instance (0=rr, 1=fx, 2=t3).
    bit         mValid[3];
    logic [7:0] mData[3];
    int         mSel[3];
    int         mPtr[3];

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        rrValid = v.rrV;
        fxValid = v.fxV;
    endtask

    // Winner is the first requester in the priority order built from the mode rules.
    function automatic int modelGrant(input int nch, input int mode, input logic [3:0] v, input int ptr);
        int order[$];
        if (mode == 1) begin
            for (int c = ptr; c < nch; c++) order.push_back(c);
            for (int c = 0; c < ptr; c++) order.push_back(c);
        end else begin
            for (int c = 0; c < nch; c++) order.push_back(c);
        end
        foreach (order[j]) begin
            if (v[order[j]]) return order[j];
        end
        return -1;
    endfunction

    task automatic modelCycle(input int d, input int nch, input int mode, input logic [3:0] v,
                              input logic [31:0] dat, input logic rdy, output logic [3:0] expIr);
        bit ld;
        int g;
        ld    = !mValid[d] || rdy;
        g     = modelGrant(nch, mode, v, mPtr[d]);
        expIr = (ld && g >= 0) ? 4'(1 << g) : 4'd0;
        if (ld) begin
            if (g >= 0) begin
                mValid[d] = 1'b1;
                mData[d]  = dat[g*8 +: 8];
                mSel[d]   = g;
                if (mode == 1) mPtr[d] = (g + 1) % nch;
            end else begin
                mValid[d] = 1'b0;
            end
        end
    endtask

    initial begin
        logic [3:0] expRr;
        logic [3:0] expFx;
        logic [3:0] expT3;
        logic [2:0] t3IrSeq[3];
        logic [1:0] t3SelSeq[3];

        total = 0;
        bad   = 0;

        tbl[0] = '{4'b1111, 4'b1010, 4'b0001, 2'd0, 8'hA0, 4'b0010, 2'd1, 8'hB1};
        tbl[1] = '{4'b1111, 4'b1010, 4'b0010, 2'd1, 8'hA1, 4'b0010, 2'd1, 8'hB1};
        tbl[2] = '{4'b1111, 4'b1010, 4'b0100, 2'd2, 8'hA2, 4'b0010, 2'd1, 8'hB1};
        tbl[3] = '{4'b1111, 4'b1010, 4'b1000, 2'd3, 8'hA3, 4'b0010, 2'd1, 8'hB1};
        tbl[4] = '{4'b1111, 4'b1010, 4'b0001, 2'd0, 8'hA0, 4'b0010, 2'd1, 8'hB1};
        tbl[5] = '{4'b1111, 4'b1010, 4'b0010, 2'd1, 8'hA1, 4'b0010, 2'd1, 8'hB1};

        // Reset with every channel requesting.
        rst_n      = 1'b0;
        rrValid    = 4'b1111;
        fxValid    = 4'b1111;
        t3Valid    = 3'b111;
        rrData     = 32'hA3A2A1A0;
        fxData     = 32'hB3B2B1B0;
        t3Data     = 24'hD2D1D0;
        rrOutReady = 1'b1;
        fxOutReady = 1'b1;
        t3OutReady = 1'b1;
        #12;
        checkOutput("reset.rr.outValid", 32'(rrOutValid), 32'd0);
        checkOutput("reset.rr.outSel", 32'(rrOutSel), 32'd0);
        checkOutput("reset.rr.outData", 32'(rrOutData), 32'd0);
        checkOutput("reset.rr.inReady", 32'(rrInReady), 32'd0);
        checkOutput("reset.fx.inReady", 32'(fxInReady), 32'd0);
        checkOutput("reset.t3.inReady", 32'(t3InReady), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin fairness and fixed priority side by side.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i]);
            #1;
            checkOutput($sformatf("tbl%0d.rr.inReady", i), 32'(rrInReady), 32'(tbl[i].rrIr));
            checkOutput($sformatf("tbl%0d.fx.inReady", i), 32'(fxInReady), 32'(tbl[i].fxIr));
            tick();
            checkOutput($sformatf("tbl%0d.rr.outValid", i), 32'(rrOutValid), 32'd1);
            checkOutput($sformatf("tbl%0d.rr.outSel", i), 32'(rrOutSel), 32'(tbl[i].rrSel));
            checkOutput($sformatf("tbl%0d.rr.outData", i), 32'(rrOutData), 32'(tbl[i].rrDat));
            checkOutput($sformatf("tbl%0d.fx.outSel", i), 32'(fxOutSel), 32'(tbl[i].fxSel));
            checkOutput($sformatf("tbl%0d.fx.outData", i), 32'(fxOutData), 32'(tbl[i].fxDat));
        end

        // Backpressure: 0x55 from channel 2 held for three stalled cycles.
        rrValid = 4'b0100;
        rrData  = 32'hA355A1A0;
        #1;
        checkOutput("bp.load.inReady", 32'(rrInReady), 32'b0100);
        tick();
        checkOutput("bp.load.outData", 32'(rrOutData), 32'h55);
        checkOutput("bp.load.outSel", 32'(rrOutSel), 32'd2);
        rrOutReady = 1'b0;
        rrValid    = 4'b1111;
        rrData     = 32'hC3C2C1C0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("bp.stall%0d.inReady", k), 32'(rrInReady), 32'd0);
            tick();
            checkOutput($sformatf("bp.stall%0d.outValid", k), 32'(rrOutValid), 32'd1);
            checkOutput($sformatf("bp.stall%0d.outData", k), 32'(rrOutData), 32'h55);
            checkOutput($sformatf("bp.stall%0d.outSel", k), 32'(rrOutSel), 32'd2);
        end
        rrOutReady = 1'b1;
        #1;
        checkOutput("bp.release.inReady", 32'(rrInReady), 32'b1000);
        tick();
        checkOutput("bp.release.outData", 32'(rrOutData), 32'hC3);
        checkOutput("bp.release.outSel", 32'(rrOutSel), 32'd3);
        checkOutput("bp.release.outValid", 32'(rrOutValid), 32'd1);

        // Single requester, then idle: pointer must stay where the last grant left it.
        rrValid = 4'b0001;
        #1;
        checkOutput("single.inReady", 32'(rrInReady), 32'b0001);
        tick();
        checkOutput("single.outSel", 32'(rrOutSel), 32'd0);
        rrValid = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            #1;
            checkOutput($sformatf("idle%0d.inReady", k), 32'(rrInReady), 32'd0);
            tick();
            checkOutput($sformatf("idle%0d.outValid", k), 32'(rrOutValid), 32'd0);
            checkOutput($sformatf("idle%0d.outData", k), 32'(rrOutData), 32'hC0);
        end
        rrValid = 4'b1111;
        #1;
        checkOutput("idle.ptrKept.inReady", 32'(rrInReady), 32'b0010);
        tick();
        checkOutput("idle.after.outData", 32'(rrOutData), 32'hC1);

        // Asynchronous reset while a word is stalled.
        rrOutReady = 1'b0;
        tick();
        checkOutput("midrst.stall.outData", 32'(rrOutData), 32'hC1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.outValid", 32'(rrOutValid), 32'd0);
        checkOutput("midrst.outSel", 32'(rrOutSel), 32'd0);
        checkOutput("midrst.outData", 32'(rrOutData), 32'd0);
        checkOutput("midrst.inReady", 32'(rrInReady), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        rrOutReady = 1'b1;
        t3Valid    = 3'b010;
        #1;
        checkOutput("midrst.ptrZero.inReady", 32'(rrInReady), 32'b0001);

        // Three-channel wrap: pointer goes 2 -> 1 via channel 0, never index 3.
        checkOutput("t3.first.inReady", 32'(t3InReady), 32'b010);
        tick();
        checkOutput("t3.first.outSel", 32'(t3OutSel), 32'd1);
        checkOutput("t3.first.outData", 32'(t3OutData), 32'hD1);
        t3Valid = 3'b001;
        #1;
        checkOutput("t3.wrap.inReady", 32'(t3InReady), 32'b001);
        tick();
        checkOutput("t3.wrap.outSel", 32'(t3OutSel), 32'd0);
        checkOutput("t3.wrap.outData", 32'(t3OutData), 32'hD0);
        t3IrSeq  = '{3'b010, 3'b100, 3'b001};
        t3SelSeq = '{2'd1, 2'd2, 2'd0};
        t3Valid  = 3'b111;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("t3.all%0d.inReady", k), 32'(t3InReady), 32'(t3IrSeq[k]));
            tick();
            checkOutput($sformatf("t3.all%0d.outSel", k), 32'(t3OutSel), 32'(t3SelSeq[k]));
        end

        // Random traffic on all three instances against the model.
        @(negedge clk);
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            mValid[d] = 1'b0;
            mData[d]  = 8'h00;
            mSel[d]   = 0;
            mPtr[d]   = 0;
        end
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 400; n++) begin
            rrValid    = 4'($urandom);
            rrData     = $urandom;
            rrOutReady = ($urandom_range(0, 3) != 0);
            fxValid    = 4'($urandom);
            fxData     = $urandom;
            fxOutReady = ($urandom_range(0, 3) != 0);
            t3Valid    = 3'($urandom);
            t3Data     = 24'($urandom);
            t3OutReady = ($urandom_range(0, 3) != 0);
            #1;
            modelCycle(0, 4, 1, rrValid, rrData, rrOutReady, expRr);
            modelCycle(1, 4, 0, fxValid, fxData, fxOutReady, expFx);
            modelCycle(2, 3, 1, {1'b0, t3Valid}, {8'h00, t3Data}, t3OutReady, expT3);
            checkOutput("rand.rr.inReady", 32'(rrInReady), 32'(expRr));
            checkOutput("rand.fx.inReady", 32'(fxInReady), 32'(expFx));
            checkOutput("rand.t3.inReady", 32'(t3InReady), 32'(expT3));
            tick();
            checkOutput("rand.rr.outValid", 32'(rrOutValid), 32'(mValid[0]));
            checkOutput("rand.rr.outData", 32'(rrOutData), 32'(mData[0]));
            checkOutput("rand.rr.outSel", 32'(rrOutSel), 32'(mSel[0]));
            checkOutput("rand.fx.outValid", 32'(fxOutValid), 32'(mValid[1]));
            checkOutput("rand.fx.outData", 32'(fxOutData), 32'(mData[1]));
            checkOutput("rand.fx.outSel", 32'(fxOutSel), 32'(mSel[1]));
            checkOutput("rand.t3.outValid", 32'(t3OutValid), 32'(mValid[2]));
            checkOutput("rand.t3.outData", 32'(t3OutData), 32'(mData[2]));
            checkOutput("rand.t3.outSel", 32'(t3OutSel), 32'(mSel[2]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
